// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// BOOT_LOADER_VERIFY_EN adds the read-back verify states.
package boot_pkg;

  localparam int unsigned CNT_W           = 10;
  localparam logic [31:0] SOC_ON_ADDR_DEF = 32'h0003_0000;
  localparam logic [31:0] SOC_ON_VAL_DEF  = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
`ifdef BOOT_LOADER_VERIFY_EN
    ST_VERIFY_REQ,
    ST_VERIFY_CHK,
`endif
    ST_SOC_ON,
    ST_DONE
  } state_e;

endpackage

// File: rtl/boot_addr_gen.sv
// Word address register plus remaining-word counter.
// Shared by the load pass and the verify read-back pass.
module boot_addr_gen
  import boot_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [31:0]      base_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             step_i,
  output logic [31:0]      addr_o,
  output logic             last_o
);

  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  // load wins over step so a pass can restart on the cycle the last word moves
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = base_i;
      rem_d  = cnt_i;
    end else if (step_i) begin
      addr_d = addr_q + 32'd4;
      rem_d  = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/boot_loader.sv
// Streams words into RAM, optionally re-reads them to check an XOR checksum,
// then writes the SoC-enable register. Optional verify: BOOT_LOADER_VERIFY_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] SOC_ON_ADDR = SOC_ON_ADDR_DEF,
  parameter logic [31:0] SOC_ON_VAL  = SOC_ON_VAL_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             cs_o,
  output logic             wr_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      wdata_o,
  input  logic [31:0]      rdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  logic [31:0]      sum_q, sum_d;
  logic             ag_load, ag_step, ag_last;
  logic [31:0]      ag_base, ag_addr;
  logic [CNT_W-1:0] ag_cnt;
  logic             ready_c, cs_c, wr_c, busy_c, done_c;
  logic [31:0]      addr_c, wdata_c;

`ifdef BOOT_LOADER_VERIFY_EN
  logic [31:0]      base_q, vsum_q, vsum_d, vsum_fin;
  logic [CNT_W-1:0] cnt_q;
  logic             vlast_q, vlast_d, err_q, err_d;

  assign vsum_fin = vsum_q ^ rdata_i;
`endif

  boot_addr_gen u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ag_load),
    .base_i (ag_base),
    .cnt_i  (ag_cnt),
    .step_i (ag_step),
    .addr_o (ag_addr),
    .last_o (ag_last)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ag_load = 1'b0;
    ag_step = 1'b0;
    ag_base = base_addr_i;
    ag_cnt  = word_cnt_i;
    ready_c = 1'b0;
    cs_c    = 1'b0;
    wr_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    busy_c  = 1'b1;
    done_c  = 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
    vsum_d  = vsum_q;
    vlast_d = vlast_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (start_i) begin
          ag_load = 1'b1;
          sum_d   = '0;
`ifdef BOOT_LOADER_VERIFY_EN
          err_d   = 1'b0;
          vsum_d  = '0;
`endif
          state_d = (word_cnt_i == '0) ? ST_SOC_ON : ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready_c = 1'b1;
        if (s_valid_i) begin
          cs_c    = 1'b1;
          wr_c    = 1'b1;
          addr_c  = ag_addr;
          wdata_c = s_data_i;
          sum_d   = sum_q ^ s_data_i;
          ag_step = 1'b1;
          if (ag_last) begin
`ifdef BOOT_LOADER_VERIFY_EN
            ag_load = 1'b1;
            ag_base = base_q;
            ag_cnt  = cnt_q;
            vsum_d  = '0;
            state_d = ST_VERIFY_REQ;
`else
            state_d = ST_SOC_ON;
`endif
          end
        end
      end
`ifdef BOOT_LOADER_VERIFY_EN
      ST_VERIFY_REQ: begin
        cs_c    = 1'b1;
        addr_c  = ag_addr;
        ag_step = 1'b1;
        vlast_d = ag_last;
        state_d = ST_VERIFY_CHK;
      end
      // read data for the request issued last cycle is on rdata_i now
      ST_VERIFY_CHK: begin
        vsum_d = vsum_fin;
        if (!vlast_q) begin
          state_d = ST_VERIFY_REQ;
        end else if (vsum_fin != sum_q) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SOC_ON;
        end
      end
`endif
      ST_SOC_ON: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = SOC_ON_ADDR;
        wdata_c = SOC_ON_VAL;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

`ifdef BOOT_LOADER_VERIFY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q  <= '0;
      cnt_q   <= '0;
      vsum_q  <= '0;
      vlast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        base_q <= base_addr_i;
        cnt_q  <= word_cnt_i;
      end
      vsum_q  <= vsum_d;
      vlast_q <= vlast_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q & ~rst_i;
`else
  logic unused_ok;
  assign unused_ok = ^{rdata_i, sum_q};
  assign err_o     = 1'b0;
`endif

  // outputs are forced quiet while reset is held so no RAM access or handshake slips out
  assign s_ready_o = ready_c & ~rst_i;
  assign cs_o      = cs_c & ~rst_i;
  assign wr_o      = wr_c & ~rst_i;
  assign busy_o    = busy_c & ~rst_i;
  assign done_o    = done_c & ~rst_i;
  assign addr_o    = rst_i ? '0 : addr_c;
  assign wdata_o   = rst_i ? '0 : wdata_c;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader against a list-of-writes reference.
// Also covers the read-back path when BOOT_LOADER_VERIFY_EN is defined.
module tb_boot_loader;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

`ifdef BOOT_LOADER_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif
  localparam logic [31:0] SOC_A = 32'h0003_0000;
  localparam logic [31:0] SOC_V = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, start_i = 1'b0, s_valid_i = 1'b0;
  logic [31:0] base_addr_i = '0, s_data_i = '0, rdata_i = '0;
  logic [9:0]  word_cnt_i = '0;
  logic        s_ready_o, cs_o, wr_o, busy_o, done_o, err_o;
  logic [31:0] addr_o, wdata_o;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  int          cs_cnt = 0, done_cnt = 0, done_cyc = -1;
  wr_t         wr_log[$], exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] words [0:511];
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0, rd_pend_val = '0;

  logic [31:0] d_base [0:2] = '{32'h0000_0800, 32'h0000_0800, 32'hFFFF_FFFC};
  int          d_cnt  [0:2] = '{3, 3, 2};
  int          d_gap  [0:2] = '{0, 2, 0};
  string       d_name [0:2] = '{"back_to_back", "gapped", "wrap"};

  boot_loader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .cs_o        (cs_o),
    .wr_o        (wr_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rdata_i     (rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM model and bus monitor: what is seen mid-cycle is what the RAM takes at the next edge
  always @(negedge clk) begin
    rdata_i = rd_pend_val;
    if (cs_o && wr_o) begin
      wr_log.push_back({addr_o, wdata_o});
      mem[addr_o] = wdata_o;
    end
    if (cs_o && !wr_o) begin
      rd_log.push_back(addr_o);
      rd_pend_val = mem.exists(addr_o) ? mem[addr_o] : 32'h0;
      if (corrupt_en && addr_o == corrupt_addr) rd_pend_val = rd_pend_val ^ 32'h0000_0100;
    end
    if (cs_o) cs_cnt++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: word i lands at base + 4*i (mod 2^32), then the SoC-enable write if allowed.
  task automatic model_load(input logic [31:0] base, input int cnt, input bit soc);
    wr_t e;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      e.a = base + 32'(4 * i);
      e.d = words[i];
      exp_q.push_back(e);
    end
    if (soc) begin
      e.a = SOC_A;
      e.d = SOC_V;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [31:0] base, input int cnt, input int stop_after,
                         input int max_gap, input bit rand_gap, input bit noisy,
                         output int drv_cyc, output bit tmo);
    wr_log.delete();
    rd_log.delete();
    cs_cnt = 0; done_cnt = 0; done_cyc = -1; tmo = 1'b0;
    start_i = 1'b1; base_addr_i = base; word_cnt_i = 10'(cnt); drv_cyc = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < stop_after; i++) begin
      int guard;
      int gap;
      bit acc;
      s_valid_i = 1'b1; s_data_i = words[i];
      acc = 1'b0; guard = 0;
      while (!acc && guard < 50) begin
        if (noisy) begin
          start_i = 1'($urandom_range(0, 1));
          base_addr_i = $urandom();
          word_cnt_i = 10'($urandom_range(0, 512));
        end
        @(negedge clk); acc = s_ready_o;
        @(posedge clk); #1; guard++;
      end
      s_valid_i = 1'b0; s_data_i = $urandom(); start_i = 1'b0;
      if (!acc) begin
        tmo = 1'b1;
        break;
      end
      gap = rand_gap ? $urandom_range(0, max_gap) : max_gap;
      if (i == stop_after - 1) gap = 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    start_i = 1'b0;
    if (stop_after == cnt && !tmo) begin
      int g = 0;
      while (done_cnt == 0 && g < 4 * cnt + 20) begin @(posedge clk); #1; g++; end
      if (done_cnt == 0) tmo = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      $display("load base=%08h cnt=%0d writes=%0d reads=%0d done_at=+%0d err=%0b",
               base, cnt, wr_log.size(), rd_log.size(), done_cyc - drv_cyc, err_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if ({s_ready_o, cs_o, wr_o, busy_o, done_o, err_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ready/cs/wr/busy/done/err=%b expected 000000",
               {s_ready_o, cs_o, wr_o, busy_o, done_o, err_o});
    end
    n_cmp++;
    if ({addr_o, wdata_o} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr=%08h wdata=%08h expected 0/0", addr_o, wdata_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_ready_o, busy_o, cs_o} !== 3'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got ready/busy/cs=%b expected 000", {s_ready_o, busy_o, cs_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int dc;
    bit tmo;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < d_cnt[s]; i++) words[i] = $urandom();
      do_load(d_base[s], d_cnt[s], d_cnt[s], d_gap[s], 1'b0, 1'b0, dc, tmo);
      model_load(d_base[s], d_cnt[s], 1'b1);
      n_cmp++;
      if (tmo) begin n_bad++; $display("FAIL %s_timeout: got no done_o expected done_o pulse", d_name[s]); end
      n_cmp++;
      if (wr_log.size() !== exp_q.size()) begin
        n_bad++;
        $display("FAIL %s_write_count: got %0d expected %0d", d_name[s], wr_log.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < wr_log.size()) begin
        n_cmp++;
        if (wr_log[k] !== exp_q[k]) begin
          n_bad++;
          $display("FAIL %s_write[%0d]: got [%08h]<=%08h expected [%08h]<=%08h", d_name[s], k,
                   wr_log[k].a, wr_log[k].d, exp_q[k].a, exp_q[k].d);
        end
      end
      n_cmp++;
      if (rd_log.size() !== VERIFY * d_cnt[s]) begin
        n_bad++;
        $display("FAIL %s_read_count: got %0d expected %0d", d_name[s], rd_log.size(), VERIFY * d_cnt[s]);
      end
      foreach (rd_log[k]) begin
        n_cmp++;
        if (rd_log[k] !== d_base[s] + 32'(4 * k)) begin
          n_bad++;
          $display("FAIL %s_read[%0d]: got %08h expected %08h", d_name[s], k, rd_log[k], d_base[s] + 32'(4 * k));
        end
      end
      n_cmp++;
      if (cs_cnt !== d_cnt[s] * (1 + VERIFY) + 1) begin
        n_bad++;
        $display("FAIL %s_cs_cycles: got %0d expected %0d", d_name[s], cs_cnt, d_cnt[s] * (1 + VERIFY) + 1);
      end
      n_cmp++;
      if (done_cnt !== 1 || err_o !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_done_err: got done_pulses=%0d err=%b expected 1/0", d_name[s], done_cnt, err_o);
      end
    end
  endtask

  task automatic test_zero();
    int dc;
    bit tmo;
    do_load(32'h0000_4000, 0, 0, 0, 1'b0, 1'b0, dc, tmo);
    n_cmp++;
    if (tmo || wr_log.size() !== 1) begin
      n_bad++;
      $display("FAIL zero_writes: got timeout=%b writes=%0d expected 0/1", tmo, wr_log.size());
    end else begin
      n_cmp++;
      if (wr_log[0] !== {SOC_A, SOC_V}) begin
        n_bad++;
        $display("FAIL zero_soc_write: got [%08h]<=%08h expected [%08h]<=%08h",
                 wr_log[0].a, wr_log[0].d, SOC_A, SOC_V);
      end
    end
    n_cmp++;
    if (done_cyc - dc !== 2 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL zero_done_latency: got +%0d (pulses %0d) expected +2 (pulses 1)", done_cyc - dc, done_cnt);
    end
    n_cmp++;
    if (cs_cnt !== 1) begin n_bad++; $display("FAIL zero_cs_cycles: got %0d expected 1", cs_cnt); end
  endtask

`ifdef BOOT_LOADER_VERIFY_EN
  task automatic test_verify_corrupt();
    int dc;
    bit tmo;
    for (int i = 0; i < 3; i++) words[i] = $urandom();
    corrupt_en = 1'b1; corrupt_addr = 32'h0000_0804;
    do_load(32'h0000_0800, 3, 3, 0, 1'b0, 1'b0, dc, tmo);
    corrupt_en = 1'b0;
    model_load(32'h0000_0800, 3, 1'b0);
    n_cmp++;
    if (tmo || wr_log.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL corrupt_write_count: got timeout=%b writes=%0d expected 0/%0d", tmo, wr_log.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < wr_log.size()) begin
      n_cmp++;
      if (wr_log[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL corrupt_write[%0d]: got [%08h]<=%08h expected [%08h]<=%08h", k,
                 wr_log[k].a, wr_log[k].d, exp_q[k].a, exp_q[k].d);
      end
    end
    n_cmp++;
    if (err_o !== 1'b1 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL corrupt_err_done: got err=%b pulses=%0d expected 1/1", err_o, done_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int dc;
    int cnt;
    bit tmo;
    logic [31:0] base;
    for (int it = 0; it < 8; it++) begin
      base = $urandom() & 32'hFFFF_FFFC;
      cnt = (it == 0) ? 512 : $urandom_range(1, 40);
      for (int i = 0; i < cnt; i++) words[i] = $urandom();
      do_load(base, cnt, cnt, 3, 1'b1, 1'b1, dc, tmo);
      model_load(base, cnt, 1'b1);
      n_cmp++;
      if (tmo || wr_log.size() !== exp_q.size()) begin
        n_bad++;
        $display("FAIL random%0d_write_count: got timeout=%b writes=%0d expected 0/%0d", it, tmo, wr_log.size(), exp_q.size());
      end
      foreach (exp_q[k]) if (k < wr_log.size()) begin
        n_cmp++;
        if (wr_log[k] !== exp_q[k]) begin
          n_bad++;
          $display("FAIL random%0d_write[%0d]: got [%08h]<=%08h expected [%08h]<=%08h", it, k,
                   wr_log[k].a, wr_log[k].d, exp_q[k].a, exp_q[k].d);
        end
      end
      n_cmp++;
      if (cs_cnt !== cnt * (1 + VERIFY) + 1 || done_cnt !== 1 || err_o !== 1'b0) begin
        n_bad++;
        $display("FAIL random%0d_summary: got cs=%0d pulses=%0d err=%b expected %0d/1/0", it,
                 cs_cnt, done_cnt, err_o, cnt * (1 + VERIFY) + 1);
      end
    end
  endtask

  task automatic test_abort();
    int dc;
    bit tmo;
    for (int i = 0; i < 4; i++) words[i] = $urandom();
    do_load(32'h0000_1000, 4, 2, 0, 1'b0, 1'b0, dc, tmo);
    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = words[2];
    @(negedge clk);
    n_cmp++;
    if ({s_ready_o, cs_o, wr_o, busy_o, done_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_during_reset: got ready/cs/wr/busy/done=%b expected 00000",
               {s_ready_o, cs_o, wr_o, busy_o, done_o});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({s_ready_o, cs_o, wr_o, busy_o, done_o, err_o, addr_o, wdata_o} !== 70'h0) begin
      n_bad++;
      $display("FAIL abort_after_reset: got ctrl=%b addr=%08h wdata=%08h expected all 0",
               {s_ready_o, cs_o, wr_o, busy_o, done_o, err_o}, addr_o, wdata_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    s_valid_i = 1'b0;
    model_load(32'h0000_1000, 2, 1'b0);
    n_cmp++;
    if (tmo || wr_log.size() !== 2 || cs_cnt !== 2 || done_cnt !== 0) begin
      n_bad++;
      $display("FAIL abort_partial: got timeout=%b writes=%0d cs=%0d pulses=%0d expected 0/2/2/0",
               tmo, wr_log.size(), cs_cnt, done_cnt);
    end
    foreach (exp_q[k]) if (k < wr_log.size()) begin
      n_cmp++;
      if (wr_log[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL abort_write[%0d]: got [%08h]<=%08h expected [%08h]<=%08h", k,
                 wr_log[k].a, wr_log[k].d, exp_q[k].a, exp_q[k].d);
      end
    end
    for (int i = 0; i < 4; i++) words[i] = $urandom();
    do_load(32'h0000_2000, 4, 4, 1, 1'b1, 1'b0, dc, tmo);
    model_load(32'h0000_2000, 4, 1'b1);
    n_cmp++;
    if (tmo || wr_log.size() !== exp_q.size() || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL reload_count: got timeout=%b writes=%0d pulses=%0d expected 0/%0d/1",
               tmo, wr_log.size(), done_cnt, exp_q.size());
    end
    foreach (exp_q[k]) if (k < wr_log.size()) begin
      n_cmp++;
      if (wr_log[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL reload_write[%0d]: got [%08h]<=%08h expected [%08h]<=%08h", k,
                 wr_log[k].a, wr_log[k].d, exp_q[k].a, exp_q[k].d);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_zero();
`ifdef BOOT_LOADER_VERIFY_EN
    test_verify_corrupt();
`endif
    test_random();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter SOC_ON_ADDR, default 32'h0003_0000; address of the SoC-enable register in the RAM.
REQ-002 SHALL have parameter SOC_ON_VAL, default 32'h0000_0001; value written to SOC_ON_ADDR at end of load.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports start_i in 1 (load request pulse), base_addr_i in 32 (byte start address, word-aligned), word_cnt_i in 10 (words to load, 0..512).
REQ-006 SHALL have ports s_valid_i in 1, s_data_i in 32, s_ready_o out 1; upstream word stream.
REQ-007 SHALL have ports cs_o out 1, wr_o out 1, addr_o out 32, wdata_o out 32, rdata_i in 32; initiator side of the RAM chip-select interface.
REQ-008 SHALL have ports busy_o out 1, done_o out 1 (one-cycle pulse), err_o out 1 (sticky).

Function
REQ-009 SHALL treat the RAM as sampling cs_o/wr_o/addr_o/wdata_o at a rising edge, with rdata_i valid the cycle after a read (cs_o=1, wr_o=0).
REQ-010 SHALL implement states IDLE, LOAD, VERIFY_REQ, VERIFY_CHK, SOC_ON, DONE.
REQ-011 IDLE: start_i=1 latches base_addr_i and word_cnt_i, clears err_o and checksum, goes to LOAD; with word_cnt_i=0 it goes to SOC_ON.
REQ-012 start_i outside IDLE SHALL be ignored.
REQ-013 LOAD: s_ready_o=1; per s_valid_i&s_ready_o cycle, drive cs_o=1, wr_o=1, addr_o=current, wdata_o=s_data_i combinationally, XOR word into checksum, advance address by 4, decrement remaining.
REQ-014 LOAD with s_valid_i=0 SHALL hold cs_o=0 and the address; no timeout.
REQ-015 After the last word is accepted, SHALL go to VERIFY_REQ (REQ-024) or SOC_ON.
REQ-016 Address arithmetic SHALL be 32-bit, wrapping modulo 2^32.
REQ-017 SOC_ON: one cycle with cs_o=1, wr_o=1, addr_o=SOC_ON_ADDR, wdata_o=SOC_ON_VAL, then DONE.
REQ-018 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 cs_o SHALL be 0 in IDLE and DONE; s_ready_o SHALL be 0 outside LOAD.

Reset
REQ-021 rst_i=1 at an edge SHALL force IDLE and set s_ready_o, cs_o, wr_o, busy_o, done_o, err_o to 0, addr_o and wdata_o to 0, counters and checksum to 0.
REQ-022 Reset mid-operation SHALL abort with no further RAM access; the partial load is not completed.
REQ-023 Stream words offered during reset SHALL NOT be accepted.

Configuration
REQ-024 Macro BOOT_LOADER_VERIFY_EN defined: after LOAD, re-read all words from base, one read per VERIFY_REQ cycle (cs_o=1, wr_o=0), XOR rdata_i in VERIFY_CHK, compare with load checksum.
REQ-025 With BOOT_LOADER_VERIFY_EN, a mismatch SHALL set err_o, skip SOC_ON, and go to DONE; a match goes to SOC_ON.
REQ-026 Without BOOT_LOADER_VERIFY_EN, VERIFY states and the verify checksum SHALL be absent, err_o is tied 0, and LOAD goes directly to SOC_ON.

Structure
REQ-027 Shared package boot_pkg SHALL hold the state enum, SOC_ON_ADDR default and the word-count width constant (10).
REQ-028 One sub-module, boot_addr_gen (address register plus remaining-word counter with load/step/last outputs), SHALL be used in LOAD and VERIFY.

Verification
REQ-029 start, base 0x800, cnt 3, words A,B,C back-to-back -> writes 0x800/0x804/0x808, then 0x0003_0000<=1, done_o pulse, err_o=0.
REQ-030 cnt 3 with s_valid_i gapped 2 cycles between words -> cs_o=0 during gaps, same addresses and data as REQ-029.
REQ-031 start with cnt 0 -> only the SOC_ON write, done_o two cycles after start.
REQ-032 VERIFY_EN, bench RAM corrupts the word at 0x804 -> err_o=1, no write to 0x0003_0000, done_o pulses.
REQ-033 rst_i asserted after the second accepted word of 4 -> all outputs 0 the next cycle, no further cs_o; a new start then loads normally.
REQ-034 base 0xFFFF_FFFC, cnt 2 -> writes to 0xFFFF_FFFC then 0x0000_0000.
